mod_addsub_serial: RTL and testbench

Digit-serial modular adder/subtractor for the GF(p) datapath. It computes (a ± b) mod p for WIDTH-bit operands by processing DIGIT bits per cycle. Each operation makes two passes: a raw add or subtract, then a correction pass. It generalises the combinational carry-slice adders into a parametrised, handshaked, multi-cycle unit that feeds the Fp2 arithmetic core.

---
 rtl/fp_arith_pkg.sv | 33 +++
 rtl/digit_addsub.sv | 32 +++
 rtl/mod_addsub_serial.sv | 177 +++++++++++++++++
 tb/tb_mod_addsub_serial.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_arith_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : fp_arith_pkg
//  Brief     : Shared definitions for the GF(p) serial arithmetic units:
//              sequencer state encoding, add/sub mode constants and a
//              ceiling-log2 helper.
//  Revision  : 1.0  initial release
// ============================================================================
package fp_arith_pkg;

    // Sequencer states of the two-pass digit-serial modular unit
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Ceiling of log2(n); returns 0 for n <= 1
    function automatic int fn_clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : fp_arith_pkg
`default_nettype wire

// File: rtl/digit_addsub.sv
`default_nettype none
// ============================================================================
//  Module    : digit_addsub
//  Brief     : Combinational DIGIT-bit adder/subtractor. With sub=0 it
//              computes x+y+cin (co = carry out); with sub=1 it computes
//              x-y-cin (co = borrow out).
//  Revision  : 1.0  initial release
// ============================================================================
module digit_addsub #(
    parameter int DIGIT = 64
) (
    input  logic             sub,
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             co
);

    logic [DIGIT:0] w_add;
    logic [DIGIT:0] w_sub;

    // One extra bit captures carry (add) or the sign of the difference (sub)
    always_comb begin
        w_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
        w_sub = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, cin};
        sum   = sub ? w_sub[DIGIT-1:0] : w_add[DIGIT-1:0];
        co    = sub ? w_sub[DIGIT]     : w_add[DIGIT];
    end

endmodule : digit_addsub
`default_nettype wire

// File: rtl/mod_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module    : mod_addsub_serial
//  Brief     : Digit-serial modular adder/subtractor, (a +/- b) mod p.
//              Pass 1 forms the raw sum/difference s, pass 2 forms the
//              corrected value t = s -/+ p; the result is picked from s or t.
//              Optional: define MOD_ADDSUB_SERIAL_PERF_EN to add the 32-bit
//              ops_done counter of completed output handshakes.
//  Revision  : 1.0  initial release
// ============================================================================
module mod_addsub_serial
    import fp_arith_pkg::*;
#(
    parameter int WIDTH = 448,
    parameter int DIGIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
    output logic [31:0]      ops_done,
`endif
    output logic [WIDTH-1:0] result
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (fn_clog2(NDIG) < 1) ? 1 : fn_clog2(NDIG);
    localparam logic [CW-1:0] C_LAST = CW'(NDIG - 1);

    seq_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic             r_cy;
    logic             r_f;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_s;
    logic [WIDTH-1:0] r_t;
    logic [WIDTH-1:0] r_result;

    logic             w_pass2;
    logic             w_sub;
    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;
    logic [DIGIT-1:0] w_sum;
    logic             w_co;
    logic             w_last;
    logic             w_sel_t;
    logic [WIDTH-1:0] w_s_ins;
    logic [WIDTH-1:0] w_s_rot;
    logic [WIDTH-1:0] w_t_ins;

    // Operand muxing for the shared digit slice: pass 2 corrects s with p
    // using the opposite operation of pass 1
    always_comb begin
        w_pass2 = (r_state == ST_PASS2);
        w_x     = w_pass2 ? r_s[DIGIT-1:0] : r_a[DIGIT-1:0];
        w_y     = w_pass2 ? r_p[DIGIT-1:0] : r_b[DIGIT-1:0];
        w_sub   = w_pass2 ? (r_mode == MODE_ADD) : (r_mode == MODE_SUB);
        w_last  = (r_cnt == C_LAST);
        // add: t when the sum overflowed or s >= p; sub: t when a < b
        w_sel_t = r_f | ((r_mode == MODE_ADD) & ~w_co);
        // new digits enter at the MSB end while the register shifts right;
        // s rotates in pass 2 so it is intact again after the last digit
        w_s_ins = (r_s >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
        w_s_rot = (r_s >> DIGIT) | (WIDTH'(r_s[DIGIT-1:0]) << (WIDTH - DIGIT));
        w_t_ins = (r_t >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
    end

    digit_addsub #(
        .DIGIT (DIGIT)
    ) u_digit (
        .sub (w_sub),
        .x   (w_x),
        .y   (w_y),
        .cin (r_cy),
        .sum (w_sum),
        .co  (w_co)
    );

    // Two-pass sequencer with registered handshake and result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mode      <= 1'b0;
            r_cy        <= 1'b0;
            r_f         <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_s         <= '0;
            r_t         <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_p     <= p;
                        r_mode  <= mode;
                        r_cy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_PASS1;
                    end
                end
                ST_PASS1: begin
                    r_a <= r_a >> DIGIT;
                    r_b <= r_b >> DIGIT;
                    r_s <= w_s_ins;
                    if (w_last) begin
                        r_f     <= w_co;
                        r_cy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_PASS2;
                    end else begin
                        r_cy  <= w_co;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PASS2: begin
                    r_p <= r_p >> DIGIT;
                    r_s <= w_s_rot;
                    r_t <= w_t_ins;
                    if (w_last) begin
                        r_result    <= w_sel_t ? w_t_ins : w_s_rot;
                        r_out_valid <= 1'b1;
                        r_cy        <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cy  <= w_co;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MOD_ADDSUB_SERIAL_PERF_EN
    logic [31:0] r_ops_done;

    // Count completed output handshakes, wrapping naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ops_done <= '0;
        end else if (r_out_valid && out_ready) begin
            r_ops_done <= r_ops_done + 32'd1;
        end
    end

    assign ops_done = r_ops_done;
`endif

    assign start_ready = (r_state == ST_IDLE);
    assign out_valid   = r_out_valid;
    assign result      = r_result;

endmodule : mod_addsub_serial
`default_nettype wire

// File: tb/tb_mod_addsub_serial.sv
`default_nettype none
// ============================================================================
//  Module    : tb_mod_addsub_serial
//  Brief     : Directed, table-driven bench for mod_addsub_serial with
//              WIDTH=16, DIGIT=4, p=0xFFF1 (latency 8 cycles).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_mod_addsub_serial;

    localparam int W   = 16;
    localparam int D   = 4;
    localparam int LAT = 8;
    localparam logic [W-1:0] P = 16'hFFF1;

    logic         clk;
    logic         rst_n;
    logic         start_valid;
    logic         start_ready;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
    logic [31:0]  ops_done;
`endif

    int n_chk;
    int n_err;
    int n_hs;

    mod_addsub_serial #(
        .WIDTH (W),
        .DIGIT (D)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .mode        (mode),
        .a           (a),
        .b           (b),
        .p           (p),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
        .ops_done    (ops_done),
`endif
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         m;
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic [W-1:0] exp;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request and wait (bounded) for out_valid; returns result and latency
    task automatic launch(input logic m, input logic [W-1:0] va, input logic [W-1:0] vb,
                          output logic [W-1:0] res, output int lat);
        int guard;
        guard = 0;
        while (!start_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("start_ready_before_issue", {31'd0, start_ready}, 32'd1);
        mode = m; a = va; b = vb; p = P; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = '0; b = '0; mode = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_hs++;
    endtask

    vec_t         vecs[8];
    logic [W-1:0] res;
    logic [W-1:0] held;
    int           lat;
    int           stray;

    initial begin
        n_chk = 0; n_err = 0; n_hs = 0;
        rst_n = 1'b0; start_valid = 1'b0; out_ready = 1'b0;
        mode = 1'b0; a = '0; b = '0; p = '0;

        vecs[0] = '{1'b0, 16'h1234, 16'h0001, 16'h1235};
        vecs[1] = '{1'b0, 16'hFFF0, 16'h0005, 16'h0004};
        vecs[2] = '{1'b0, 16'h8000, 16'h7FF1, 16'h0000};
        vecs[3] = '{1'b1, 16'h0003, 16'h0005, 16'hFFEF};
        vecs[4] = '{1'b1, 16'h7777, 16'h7777, 16'h0000};
        vecs[5] = '{1'b0, 16'hFFF0, 16'hFFF0, 16'hFFEF};
        vecs[6] = '{1'b1, 16'h0000, 16'hFFF0, 16'h0001};
        vecs[7] = '{1'b1, 16'h5000, 16'h1234, 16'h3DCC};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_start_ready", {31'd0, start_ready}, 32'd1);
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
        chk("reset_ops_done", ops_done, 32'd0);
`endif

        // Table-driven functional vectors, each also checks latency
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].m, vecs[i].va, vecs[i].vb, res, lat);
            chk($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp});
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            handshake();
            chk($sformatf("vec%0d_ready_after", i), {31'd0, start_ready}, 32'd1);
            chk($sformatf("vec%0d_valid_after", i), {31'd0, out_valid}, 32'd0);
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
            if (i == 2) chk("ops_done_three", ops_done, 32'd3);
`endif
            @(posedge clk); #1;
        end

        // Backpressure: result held, start ignored while DONE
        launch(1'b0, 16'h0100, 16'h0200, res, lat);
        chk("bp_result", {16'd0, res}, 32'h0300);
        held = result;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                mode = 1'b0; a = 16'h0001; b = 16'h0001; start_valid = 1'b1;
            end else begin
                start_valid = 1'b0;
            end
            @(posedge clk); #1;
            chk($sformatf("bp_stable_%0d", k), {16'd0, result}, {16'd0, held});
            chk($sformatf("bp_ready_low_%0d", k), {31'd0, start_ready}, 32'd0);
            chk($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
        end
        start_valid = 1'b0;
        handshake();
        chk("bp_ready_return", {31'd0, start_ready}, 32'd1);
        stray = 0;
        for (int k = 0; k < 2 * LAT + 2; k++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        chk("bp_pulse_ignored", stray, 0);

        // Reset during PASS2
        launch_partial();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_result", {16'd0, result}, 32'd0);
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
        chk("rst_mid_ops_done", ops_done, 32'd0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_ready", {31'd0, start_ready}, 32'd1);
        stray = 0;
        for (int k = 0; k < 2 * LAT; k++) begin
            @(posedge clk); #1;
            if (out_valid) stray++;
        end
        chk("rst_mid_no_partial", stray, 0);
        launch(1'b0, 16'h0010, 16'h0020, res, lat);
        chk("post_rst_result", {16'd0, res}, 32'h0030);
        chk("post_rst_latency", lat, LAT);
        handshake();
`ifdef MOD_ADDSUB_SERIAL_PERF_EN
        chk("post_rst_ops_done", ops_done, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Start an add and stop 6 cycles after acceptance (inside PASS2)
    task automatic launch_partial();
        mode = 1'b0; a = 16'h4444; b = 16'h1111; p = P; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pass2_not_done", {31'd0, out_valid}, 32'd0);
    endtask

endmodule : tb_mod_addsub_serial
`default_nettype wire
